// File: rtl/sqrt_fp_rnd.sv
// sqrt_fp_rnd -- iterative fixed-point square root (shift-subtract, 2 radicand
// bits per clock).
//
// Computes rt = floor(sqrt(rad * 2^FBITS)) and rm = rad * 2^FBITS - rt^2 in
// ITER = (WIDTH+FBITS)/2 clock cycles. Both rad and root are unsigned
// Q(WIDTH-FBITS).FBITS values.
//
// Optional build macro: SQRT_FP_ROUND_EN
//   When it is defined, one ROUND cycle is added after the iterations.
//   root = rt+1 when rm > rt, otherwise root = rt.
//   root saturates at 2^WIDTH-1.
//   rem still reports the truncation remainder.
//
// Parameters:
//   WIDTH  radicand/root word width. WIDTH+FBITS must be even.
//   FBITS  fractional bits. FBITS must be less than WIDTH.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin a calculation on the current rad (accepted in IDLE or DONE)
//   abort  cancel a running calculation (ignored when not busy)
//   rad    radicand
//   busy   calculation in progress
//   valid  one-cycle pulse when root/rem have been updated
//   root   square root result
//   rem    truncation remainder, in units of 2^-2FBITS
module sqrt_fp_rnd #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] rad,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH:0]   rem
);

  localparam int ITER = (WIDTH + FBITS) / 2;
  localparam int XW   = 2 * ITER;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

`ifdef SQRT_FP_ROUND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t          state, state_nxt;
  logic [XW-1:0]   x;        // radicand shifted left two bits per iteration
  logic [ITER-1:0] rt;       // partial root
  logic [ITER+1:0] rm;       // partial remainder
  logic [CW-1:0]   cnt;      // iteration index

  logic [ITER+1:0] rm_trial;
  logic [ITER+1:0] test;
  logic            ge;
  logic [ITER+1:0] rm_nxt;
  logic [ITER-1:0] rt_nxt;
  logic            accept;
  logic            last;

`ifdef SQRT_FP_ROUND_EN
  // Round to nearest. The true root lies above rt+0.5 exactly when rm > rt.
  function automatic logic [WIDTH-1:0] round_sat(input logic [ITER-1:0] t,
                                                 input logic [ITER+1:0] m);
    logic          up;
    logic [WIDTH:0] sum;
    up  = (m > (ITER+2)'(t));
    sum = (WIDTH+1)'(t) + (WIDTH+1)'(up);
    if (sum[WIDTH]) return {WIDTH{1'b1}};
    return sum[WIDTH-1:0];
  endfunction
`endif

  // One shift-subtract step: bring down the next two radicand bits and try
  // to subtract 4*rt+1.
  always_comb begin
    rm_trial = {rm[ITER-1:0], x[XW-1 -: 2]};
    test     = {rt, 2'b01};
    ge       = (rm_trial >= test);
    rm_nxt   = ge ? (rm_trial - test) : rm_trial;
    rt_nxt   = {rt[ITER-2:0], ge};
  end

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (abort)     state_nxt = IDLE;
`ifdef SQRT_FP_ROUND_EN
        else if (last) state_nxt = ROUND;
`else
        else if (last) state_nxt = DONE;
`endif
      end
`ifdef SQRT_FP_ROUND_EN
      ROUND: begin
        busy = 1'b1;
        if (abort) state_nxt = IDLE;
        else       state_nxt = DONE;
      end
`endif
      DONE: begin
        valid = 1'b1;
        if (start) state_nxt = CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- datapath: accumulators, then result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      rt   <= '0;
      rm   <= '0;
      cnt  <= '0;
      root <= '0;
      rem  <= '0;
    end else if (accept) begin
      x   <= {rad, {FBITS{1'b0}}};
      rt  <= '0;
      rm  <= '0;
      cnt <= '0;
    end else if (state == CALC && !abort) begin
      x   <= x << 2;
      rt  <= rt_nxt;
      rm  <= rm_nxt;
      cnt <= cnt + CW'(1);
`ifndef SQRT_FP_ROUND_EN
      if (last) begin
        root <= WIDTH'(rt_nxt);
        rem  <= (WIDTH+1)'(rm_nxt);
      end
`endif
    end
`ifdef SQRT_FP_ROUND_EN
    else if (state == ROUND && !abort) begin
      root <= round_sat(rt, rm);
      rem  <= (WIDTH+1)'(rm);
    end
`endif
  end

endmodule
